// File: rtl/ex_mul_sequencer.sv
// EX-stage multi-cycle MUL sequencer: radix-2 shift-add multiplier that stalls the pipeline until done.
// Optional MUL_EARLY_EXIT_EN: finish RUN as soon as the remaining multiplier bits are all zero.
module ex_mul_sequencer #(
  parameter int unsigned DATA_W   = 32,
  parameter logic [3:0]  MUL_CODE = 4'b1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [3:0]        ALUCtrl_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] result_o,
  output logic              result_valid_o
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e              state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [DATA_W-1:0]   acc_q,    acc_d;
  logic [DATA_W-1:0]   mcand_q,  mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                start;
  logic                last;
  logic [DATA_W-1:0]   acc_sum;

  assign start = valid_i & (ALUCtrl_i == MUL_CODE) & ~flush_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    acc_sum  = mplier_q[0] ? acc_q + mcand_q : acc_q;
`ifdef MUL_EARLY_EXIT_EN
    last     = (cnt_q == CNT_W'(DATA_W - 1)) || ((mplier_q >> 1) == '0);
`else
    last     = (cnt_q == CNT_W'(DATA_W - 1));
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = rs1_data_i;
          mplier_d = rs2_data_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last) begin
          state_d  = S_DONE;
          result_d = acc_sum;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flush wins over start and completion; the held result is left untouched.
    if (flush_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
    end
  end

  assign stall_o        = ((state_q == S_IDLE) & start) | ((state_q == S_RUN) & ~flush_i);
  assign busy_o         = (state_q != S_IDLE);
  assign result_o       = result_q;
  assign result_valid_o = (state_q == S_DONE) & ~flush_i;

endmodule
